// File: rtl/pipeline_ex_stage.sv
// Execute stage: ALU, operand-B select and the EX/MEM pipeline register.
// Optional shift-add multiplier with Stall, enabled by PIPE_EX_MUL_EN.
module pipeline_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_Valid,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemToReg,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_ALUSrc,
  input  logic [3:0]        ID_EX_ALUOp,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  input  logic [REG_W-1:0]  ID_EX_WriteReg,
  output logic              Stall,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemToReg,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemWrite,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [DATA_W-1:0] EX_MEM_Data,
  output logic [REG_W-1:0]  EX_MEM_WriteReg,
  output logic              EX_MEM_Zero
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_d;
  logic              slt_lt;

  logic              rw_d;
  logic              m2r_d;
  logic              mr_d;
  logic              mw_d;
  logic [DATA_W-1:0] res_d;
  logic [DATA_W-1:0] data_d;
  logic [REG_W-1:0]  wr_d;
  logic              zero_d;

  // Operand B select and signed compare
  always_comb begin
    op_b   = ID_EX_ALUSrc ? ID_EX_Imm : ID_EX_ReadData2;
    slt_lt = $signed(ID_EX_ReadData1) < $signed(op_b);
  end

  // Single-cycle ALU; unsupported codes give 0
  always_comb begin
    alu_d = '0;
    case (ID_EX_ALUOp)
      OP_AND:  alu_d = ID_EX_ReadData1 & op_b;
      OP_OR:   alu_d = ID_EX_ReadData1 | op_b;
      OP_ADD:  alu_d = ID_EX_ReadData1 + op_b;
      OP_SUB:  alu_d = ID_EX_ReadData1 - op_b;
      OP_SLT:  alu_d = DATA_W'(slt_lt);
      OP_NOR:  alu_d = ~(ID_EX_ReadData1 | op_b);
      OP_SLL:  alu_d = ID_EX_ReadData1 << op_b[SH_W-1:0];
      OP_SRL:  alu_d = ID_EX_ReadData1 >> op_b[SH_W-1:0];
      default: alu_d = '0;
    endcase
  end

  // Next EX/MEM contents for the single-cycle path (bubble when not valid)
  always_comb begin
    rw_d   = 1'b0;
    m2r_d  = 1'b0;
    mr_d   = 1'b0;
    mw_d   = 1'b0;
    res_d  = '0;
    data_d = '0;
    wr_d   = '0;
    zero_d = 1'b1;
    if (ID_EX_Valid) begin
      rw_d   = ID_EX_RegWrite;
      m2r_d  = ID_EX_MemToReg;
      mr_d   = ID_EX_MemRead;
      mw_d   = ID_EX_MemWrite;
      res_d  = alu_d;
      data_d = ID_EX_ReadData2;
      wr_d   = ID_EX_WriteReg;
      zero_d = (alu_d == '0);
    end
  end

`ifdef PIPE_EX_MUL_EN

  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [SH_W-1:0]   cnt_q;
  logic              h_rw_q;
  logic              h_m2r_q;
  logic              h_mr_q;
  logic              h_mw_q;
  logic [DATA_W-1:0] h_data_q;
  logic [REG_W-1:0]  h_wr_q;
  logic              mul_issue;

  assign mul_issue = (state_q == S_IDLE) && ID_EX_Valid &&
                     (ID_EX_ALUOp == OP_MUL);
  assign Stall = rst && (mul_issue || (state_q == S_RUN));

  // Multiplier FSM and EX/MEM register; bubbles while the multiply runs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      mcand_q          <= '0;
      mplier_q         <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      h_rw_q           <= 1'b0;
      h_m2r_q          <= 1'b0;
      h_mr_q           <= 1'b0;
      h_mw_q           <= 1'b0;
      h_data_q         <= '0;
      h_wr_q           <= '0;
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_MemToReg  <= 1'b0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_ALUResult <= '0;
      EX_MEM_Data      <= '0;
      EX_MEM_WriteReg  <= '0;
      EX_MEM_Zero      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_issue) begin
            state_q          <= S_RUN;
            mcand_q          <= ID_EX_ReadData1;
            mplier_q         <= op_b;
            acc_q            <= '0;
            cnt_q            <= '0;
            h_rw_q           <= ID_EX_RegWrite;
            h_m2r_q          <= ID_EX_MemToReg;
            h_mr_q           <= ID_EX_MemRead;
            h_mw_q           <= ID_EX_MemWrite;
            h_data_q         <= ID_EX_ReadData2;
            h_wr_q           <= ID_EX_WriteReg;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemToReg  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
            EX_MEM_ALUResult <= '0;
            EX_MEM_Data      <= '0;
            EX_MEM_WriteReg  <= '0;
            EX_MEM_Zero      <= 1'b1;
          end else begin
            EX_MEM_RegWrite  <= rw_d;
            EX_MEM_MemToReg  <= m2r_d;
            EX_MEM_MemRead   <= mr_d;
            EX_MEM_MemWrite  <= mw_d;
            EX_MEM_ALUResult <= res_d;
            EX_MEM_Data      <= data_d;
            EX_MEM_WriteReg  <= wr_d;
            EX_MEM_Zero      <= zero_d;
          end
        end
        S_RUN: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q          <= mcand_q << 1;
          mplier_q         <= mplier_q >> 1;
          cnt_q            <= cnt_q + 1'b1;
          if (cnt_q == SH_W'(DATA_W - 1)) begin
            state_q <= S_DONE;
          end
          EX_MEM_RegWrite  <= 1'b0;
          EX_MEM_MemToReg  <= 1'b0;
          EX_MEM_MemRead   <= 1'b0;
          EX_MEM_MemWrite  <= 1'b0;
          EX_MEM_ALUResult <= '0;
          EX_MEM_Data      <= '0;
          EX_MEM_WriteReg  <= '0;
          EX_MEM_Zero      <= 1'b1;
        end
        S_DONE: begin
          state_q          <= S_IDLE;
          EX_MEM_RegWrite  <= h_rw_q;
          EX_MEM_MemToReg  <= h_m2r_q;
          EX_MEM_MemRead   <= h_mr_q;
          EX_MEM_MemWrite  <= h_mw_q;
          EX_MEM_ALUResult <= acc_q;
          EX_MEM_Data      <= h_data_q;
          EX_MEM_WriteReg  <= h_wr_q;
          EX_MEM_Zero      <= (acc_q == '0);
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`else

  assign Stall = 1'b0;

  // EX/MEM pipeline register, single-cycle only
  always_ff @(posedge clk) begin
    if (!rst) begin
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_MemToReg  <= 1'b0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_ALUResult <= '0;
      EX_MEM_Data      <= '0;
      EX_MEM_WriteReg  <= '0;
      EX_MEM_Zero      <= 1'b0;
    end else begin
      EX_MEM_RegWrite  <= rw_d;
      EX_MEM_MemToReg  <= m2r_d;
      EX_MEM_MemRead   <= mr_d;
      EX_MEM_MemWrite  <= mw_d;
      EX_MEM_ALUResult <= res_d;
      EX_MEM_Data      <= data_d;
      EX_MEM_WriteReg  <= wr_d;
      EX_MEM_Zero      <= zero_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Directed bench for pipeline_ex_stage: vector table plus
// hand-written multiply / reset-abort sequences.
module tb_pipeline_ex_stage;

  logic        clk;
  logic        rst;
  logic        ID_EX_Valid;
  logic        ID_EX_RegWrite;
  logic        ID_EX_MemToReg;
  logic        ID_EX_MemRead;
  logic        ID_EX_MemWrite;
  logic        ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_ReadData1;
  logic [31:0] ID_EX_ReadData2;
  logic [31:0] ID_EX_Imm;
  logic [4:0]  ID_EX_WriteReg;
  logic        Stall;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemToReg;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_Data;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_Zero;

  int total = 0;
  int bad   = 0;

  pipeline_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_EX_Valid      (ID_EX_Valid),
    .ID_EX_RegWrite   (ID_EX_RegWrite),
    .ID_EX_MemToReg   (ID_EX_MemToReg),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_MemWrite   (ID_EX_MemWrite),
    .ID_EX_ALUSrc     (ID_EX_ALUSrc),
    .ID_EX_ALUOp      (ID_EX_ALUOp),
    .ID_EX_ReadData1  (ID_EX_ReadData1),
    .ID_EX_ReadData2  (ID_EX_ReadData2),
    .ID_EX_Imm        (ID_EX_Imm),
    .ID_EX_WriteReg   (ID_EX_WriteReg),
    .Stall            (Stall),
    .EX_MEM_RegWrite  (EX_MEM_RegWrite),
    .EX_MEM_MemToReg  (EX_MEM_MemToReg),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_ALUResult (EX_MEM_ALUResult),
    .EX_MEM_Data      (EX_MEM_Data),
    .EX_MEM_WriteReg  (EX_MEM_WriteReg),
    .EX_MEM_Zero      (EX_MEM_Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  ctl;
    logic        src;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic [3:0]  e_ctl;
    logic [31:0] e_res;
    logic [31:0] e_data;
    logic [4:0]  e_wr;
    logic        e_zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl_out();
    return {EX_MEM_RegWrite, EX_MEM_MemToReg,
            EX_MEM_MemRead, EX_MEM_MemWrite};
  endfunction

  task automatic drive(input logic v, input logic [3:0] ctl,
                       input logic src, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] wr);
    ID_EX_Valid     = v;
    ID_EX_RegWrite  = ctl[3];
    ID_EX_MemToReg  = ctl[2];
    ID_EX_MemRead   = ctl[1];
    ID_EX_MemWrite  = ctl[0];
    ID_EX_ALUSrc    = src;
    ID_EX_ALUOp     = op;
    ID_EX_ReadData1 = a;
    ID_EX_ReadData2 = rd2;
    ID_EX_Imm       = imm;
    ID_EX_WriteReg  = wr;
  endtask

`ifdef PIPE_EX_MUL_EN
  task automatic mul_op(input string nm, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr,
                        input logic [31:0] exp);
    int sc;
    int cbad;
    drive(1'b1, 4'b1000, 1'b0, 4'b1010, a, b, 32'hDEAD, wr);
    #1;
    sc   = Stall ? 1 : 0;
    cbad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        ID_EX_ReadData1 = 32'h5;
        ID_EX_ReadData2 = 32'h9;
        #1;
      end
      if (ctl_out() != 4'b0000 || EX_MEM_ALUResult != 32'h0)
        cbad++;
      if (!Stall) break;
      sc++;
    end
    chk({nm, " stall_cycles"}, sc, 32'd33);
    chk({nm, " bubbles_bad"}, cbad, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " res"}, EX_MEM_ALUResult, exp);
    chk({nm, " ctl"}, {28'd0, ctl_out()}, 32'h8);
    chk({nm, " data"}, EX_MEM_Data, b);
    chk({nm, " wr"}, {27'd0, EX_MEM_WriteReg}, {27'd0, wr});
    chkb({nm, " zero"}, EX_MEM_Zero, exp == 32'h0);
  endtask
`endif

  initial begin
    vec_t t;
    int   rwc;

    // v ctl src op a rd2 imm wr | e_ctl e_res e_data e_wr e_zero
    vecs.push_back('{1'b1, 4'b1110, 1'b1, 4'b0010, 32'd20, 32'd20,
                     32'd20, 5'd10, 4'b1110, 32'd40, 32'd20, 5'd10,
                     1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0110, 32'd7, 32'd7,
                     32'd0, 5'd3, 4'b1000, 32'd0, 32'd7, 5'd3, 1'b1});
    vecs.push_back('{1'b1, 4'b1000, 1'b1, 4'b0111, 32'hFFFFFFFF,
                     32'd5, 32'd1, 5'd4, 4'b1000, 32'd1, 32'd5, 5'd4,
                     1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0010, 32'hFFFFFFFF,
                     32'd1, 32'd0, 5'd5, 4'b1000, 32'd0, 32'd1, 5'd5,
                     1'b1});
    vecs.push_back('{1'b1, 4'b1000, 1'b1, 4'b1000, 32'd1, 32'd0,
                     32'd31, 5'd6, 4'b1000, 32'h80000000, 32'd0, 5'd6,
                     1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0000, 32'hF0F0,
                     32'hFF00, 32'd0, 5'd7, 4'b1000, 32'hF000,
                     32'hFF00, 5'd7, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0001, 32'hF0F0,
                     32'hFF00, 32'd0, 5'd7, 4'b1000, 32'hFFF0,
                     32'hFF00, 5'd7, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b1100, 32'd0, 32'd0,
                     32'd0, 5'd8, 4'b1000, 32'hFFFFFFFF, 32'd0, 5'd8,
                     1'b0});
    vecs.push_back('{1'b1, 4'b0001, 1'b0, 4'b1001, 32'h80000000,
                     32'd4, 32'd0, 5'd9, 4'b0001, 32'h08000000, 32'd4,
                     5'd9, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0011, 32'd5, 32'd6,
                     32'd0, 5'd11, 4'b1000, 32'd0, 32'd6, 5'd11, 1'b1});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 32'd5, 32'd6,
                     32'd7, 5'd12, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1});
    vecs.push_back('{1'b1, 4'b1000, 1'b1, 4'b1000, 32'd3, 32'd0,
                     32'h21, 5'd13, 4'b1000, 32'd6, 32'd0, 5'd13, 1'b0});
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b0111, 32'd1,
                     32'hFFFFFFFF, 32'd0, 5'd14, 4'b1000, 32'd0,
                     32'hFFFFFFFF, 5'd14, 1'b1});
    vecs.push_back('{1'b1, 4'b1000, 1'b1, 4'b0110, 32'd3, 32'd0,
                     32'd5, 5'd15, 4'b1000, 32'hFFFFFFFE, 32'd0, 5'd15,
                     1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b0, 4'b1010, 32'd1, 32'd2,
                     32'd3, 5'd17, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1});
`ifndef PIPE_EX_MUL_EN
    vecs.push_back('{1'b1, 4'b1000, 1'b0, 4'b1010, 32'd1234,
                     32'd5678, 32'd0, 5'd16, 4'b1000, 32'd0, 32'd5678,
                     5'd16, 1'b1});
`endif

    // Reset with busy-looking inputs
    rst = 1'b0;
    drive(1'b1, 4'b1111, 1'b0, 4'b1010, 32'd1234, 32'd5678, 32'd9,
          5'd31);
    @(posedge clk);
    @(posedge clk);
    #1;
    chkb("rst stall", Stall, 1'b0);
    chk("rst ctl", {28'd0, ctl_out()}, 32'd0);
    chk("rst res", EX_MEM_ALUResult, 32'd0);
    chk("rst data", EX_MEM_Data, 32'd0);
    chk("rst wr", {27'd0, EX_MEM_WriteReg}, 32'd0);
    chkb("rst zero", EX_MEM_Zero, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ID_EX_Valid = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      @(negedge clk);
      drive(t.v, t.ctl, t.src, t.op, t.a, t.rd2, t.imm, t.wr);
      #1;
      chkb($sformatf("v%0d stall", i), Stall, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ctl", i), {28'd0, ctl_out()},
          {28'd0, t.e_ctl});
      chk($sformatf("v%0d res", i), EX_MEM_ALUResult, t.e_res);
      chk($sformatf("v%0d data", i), EX_MEM_Data, t.e_data);
      chk($sformatf("v%0d wr", i), {27'd0, EX_MEM_WriteReg},
          {27'd0, t.e_wr});
      chkb($sformatf("v%0d zero", i), EX_MEM_Zero, t.e_zero);
    end

`ifdef PIPE_EX_MUL_EN
    // Multiply, then a back-to-back second multiply
    @(negedge clk);
    mul_op("mul1", 32'd1234, 32'd5678, 5'd7, 32'd7006652);
    mul_op("mul2", 32'h10000, 32'h10000, 5'd9, 32'd0);
    ID_EX_Valid = 1'b0;

    // Reset during the 10th RUN cycle aborts the multiply
    @(negedge clk);
    drive(1'b1, 4'b1000, 1'b0, 4'b1010, 32'd1234, 32'd5678, 32'd0,
          5'd7);
    repeat (10) @(posedge clk);
    #1;
    chkb("abort stall_before", Stall, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chkb("abort stall_rst", Stall, 1'b0);
    chk("abort ctl", {28'd0, ctl_out()}, 32'd0);
    chk("abort res", EX_MEM_ALUResult, 32'd0);
    rst = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 4'b0010, 32'd3, 32'd4, 32'd0, 5'd2);
    #1;
    chkb("abort stall_after", Stall, 1'b0);
    @(posedge clk);
    #1;
    chk("abort add", EX_MEM_ALUResult, 32'd7);
    chk("abort add_ctl", {28'd0, ctl_out()}, 32'h8);
    ID_EX_Valid = 1'b0;
    rwc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (EX_MEM_RegWrite || Stall) rwc++;
    end
    chk("abort no_late_write", rwc, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
